// File: rtl/bus_pkg.sv
// Shared types and constants for the bus source driver: FSM states, select classes, counter width.
// Pure declarations; no logic, no latency, no flow control.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    ERROR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_e;

  localparam int ERR_CNT_WIDTH      = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_SRC    = 24;

endpackage

// File: rtl/bus_source_driver_onehot_encoder.sv
// Combinational one-hot to binary encoder that also classifies the select as none/one/multi.
// Zero latency; no flow control, the caller decides when the result is used.
module onehot_encoder
  import bus_pkg::*;
#(
  parameter int NUM_SRC   = DEFAULT_NUM_SRC,
  parameter int SEL_WIDTH = 5
) (
  input  logic [NUM_SRC-1:0]   out_en,
  output logic [SEL_WIDTH-1:0] enc_idx,
  output sel_class_e           sel_class
);

  logic [1:0] ones;

  // Bit count saturates at 2: only the none/one/many distinction matters.
  always_comb begin
    ones    = 2'd0;
    enc_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (out_en[k]) begin
        enc_idx = SEL_WIDTH'(k);
        if (ones != 2'd2) begin
          ones = ones + 2'd1;
        end
      end
    end
  end

  always_comb begin
    sel_class = SEL_MULTI;
    if (ones == 2'd0) begin
      sel_class = SEL_NONE;
    end else if (ones == 2'd1) begin
      sel_class = SEL_ONE;
    end
  end

endmodule

// File: rtl/bus_source_driver.sv
// Registers one selected source word onto BusMuxOut, holds it HOLD_CYCLES cycles, flags multi-driver selects.
// One-cycle capture latency; ready drops during hold and in ERROR (req not queued). Macro BUS_KEEPER_EN keeps the last word when idle.
module bus_source_driver
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int NUM_SRC     = DEFAULT_NUM_SRC,
  parameter int SEL_WIDTH   = 5,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            out_en,
  input  logic                          req,
  input  logic                          err_clr,
  output logic                          ready,
  output logic [DATA_WIDTH-1:0]         bus_out,
  output logic                          bus_valid,
  output logic [SEL_WIDTH-1:0]          sel_idx,
  output logic                          err,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    bus_out_q, bus_out_d;
  logic                     bus_valid_q, bus_valid_d;
  logic [SEL_WIDTH-1:0]     sel_idx_q, sel_idx_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [SEL_WIDTH-1:0]     enc_idx;
  sel_class_e               sel_class;
  logic [DATA_WIDTH-1:0]    sel_word;
  logic                     rdy_int;
  logic                     accept;

  onehot_encoder #(
    .NUM_SRC   (NUM_SRC),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_enc (
    .out_en    (out_en),
    .enc_idx   (enc_idx),
    .sel_class (sel_class)
  );

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (enc_idx == SEL_WIDTH'(k)) begin
        sel_word = src_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The final hold cycle accepts the next request so transfers chain without a bubble.
  assign rdy_int = (state_q == IDLE) || ((state_q == DRIVE) && (cnt_q == '0));
  assign ready   = rdy_int || !clear_n;
  assign accept  = req && rdy_int;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    sel_idx_d   = sel_idx_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
        end
      end
      ERROR: begin
        if (err_clr) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
      end
    endcase

    if (accept) begin
      case (sel_class)
        SEL_ONE: begin
          state_d     = DRIVE;
          cnt_d       = CNT_LOAD;
          bus_out_d   = sel_word;
          bus_valid_d = 1'b1;
          sel_idx_d   = enc_idx;
        end
        SEL_MULTI: begin
          state_d     = ERROR;
          cnt_d       = '0;
          bus_valid_d = 1'b0;
          err_d       = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          bus_valid_d = 1'b0;
        end
      endcase
    end

`ifndef BUS_KEEPER_EN
    if (!bus_valid_d) begin
      bus_out_d = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      sel_idx_q   <= sel_idx_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign sel_idx   = sel_idx_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bus_source_driver.sv
// Directed bench for bus_source_driver: one instance with HOLD_CYCLES=1, one with HOLD_CYCLES=3.
// Expected bus_out after idle/error follows BUS_KEEPER_EN.
module tb_bus_source_driver;
  localparam int DW = 32;
  localparam int NS = 24;
  localparam int SW = 5;
`ifdef BUS_KEEPER_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear_n;
  logic [NS*DW-1:0] src_data;

  logic [NS-1:0] out_en1, out_en3;
  logic req1, req3, err_clr1, err_clr3;
  logic ready1, ready3, bus_valid1, bus_valid3, err1, err3;
  logic [DW-1:0] bus_out1, bus_out3;
  logic [SW-1:0] sel_idx1, sel_idx3;
  logic [7:0] err_cnt1, err_cnt3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  bus_source_driver #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_WIDTH(SW), .HOLD_CYCLES(1)) u_h1 (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .out_en(out_en1), .req(req1),
    .err_clr(err_clr1), .ready(ready1), .bus_out(bus_out1), .bus_valid(bus_valid1),
    .sel_idx(sel_idx1), .err(err1), .err_cnt(err_cnt1)
  );

  bus_source_driver #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_WIDTH(SW), .HOLD_CYCLES(3)) u_h3 (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .out_en(out_en3), .req(req3),
    .err_clr(err_clr3), .ready(ready3), .bus_out(bus_out3), .bus_valid(bus_valid3),
    .sel_idx(sel_idx3), .err(err3), .err_cnt(err_cnt3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    src_data = '0;
    out_en1 = '0; out_en3 = '0;
    req1 = 1'b0; req3 = 1'b0; err_clr1 = 1'b0; err_clr3 = 1'b0;
    #3;
    tests_run++;
    if ({bus_valid1, bus_out1, sel_idx1, err1, err_cnt1, ready1} !== {1'b0, 32'h0, 5'd0, 1'b0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_h1: valid=%b out=%h sel=%0d err=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1",
               bus_valid1, bus_out1, sel_idx1, err1, err_cnt1, ready1);
    end
    tests_run++;
    if ({bus_valid3, bus_out3, err3, err_cnt3, ready3} !== {1'b0, 32'h0, 1'b0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_h3: valid=%b out=%h err=%b cnt=%0d rdy=%b, want 0 0 0 0 1",
               bus_valid3, bus_out3, err3, err_cnt3, ready3);
    end
    step();
    step();
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    src_data[5*DW +: DW] = 32'hDEADBEEF;
    out_en1 = 24'd1 << 5;
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    out_en1 = '0;
    tests_run++;
    if ({bus_valid1, bus_out1, sel_idx1} !== {1'b1, 32'hDEADBEEF, 5'd5}) begin
      tests_failed++;
      $display("FAIL single_capture: valid=%b out=%h sel=%0d, want 1 deadbeef 5", bus_valid1, bus_out1, sel_idx1);
    end
    step();
    tests_run++;
    if ({bus_valid1, bus_out1} !== {1'b0, (KEEP ? 32'hDEADBEEF : 32'h0)}) begin
      tests_failed++;
      $display("FAIL single_drop: valid=%b out=%h, want 0 %h", bus_valid1, bus_out1, (KEEP ? 32'hDEADBEEF : 32'h0));
    end
  endtask

  task automatic test_back_to_back();
    src_data[5*DW +: DW] = 32'hDEADBEEF;
    out_en3 = 24'd1 << 5;
    req3 = 1'b1;
    step();
    // Blocked request while the hold counter is non-zero.
    out_en3 = 24'd1 << 9;
    src_data[5*DW +: DW] = 32'h12345678;
    src_data[9*DW +: DW] = 32'h11111111;
    tests_run++;
    if ({bus_valid3, bus_out3, sel_idx3, ready3} !== {1'b1, 32'hDEADBEEF, 5'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL hold_first: valid=%b out=%h sel=%0d rdy=%b, want 1 deadbeef 5 0", bus_valid3, bus_out3, sel_idx3, ready3);
    end
    step();
    req3 = 1'b0;
    tests_run++;
    if ({bus_valid3, bus_out3, sel_idx3} !== {1'b1, 32'hDEADBEEF, 5'd5}) begin
      tests_failed++;
      $display("FAIL hold_frozen: valid=%b out=%h sel=%0d, want 1 deadbeef 5", bus_valid3, bus_out3, sel_idx3);
    end
    step();
    tests_run++;
    if ({bus_valid3, bus_out3, ready3} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      tests_failed++;
      $display("FAIL hold_last: valid=%b out=%h rdy=%b, want 1 deadbeef 1", bus_valid3, bus_out3, ready3);
    end
    src_data[9*DW +: DW] = 32'hCAFEF00D;
    req3 = 1'b1;
    step();
    req3 = 1'b0;
    out_en3 = '0;
    tests_run++;
    if ({bus_valid3, bus_out3, sel_idx3} !== {1'b1, 32'hCAFEF00D, 5'd9}) begin
      tests_failed++;
      $display("FAIL b2b_no_bubble: valid=%b out=%h sel=%0d, want 1 cafef00d 9", bus_valid3, bus_out3, sel_idx3);
    end
    step();
    step();
    tests_run++;
    if (bus_valid3 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_third_cycle: valid=%b, want 1", bus_valid3);
    end
    step();
    tests_run++;
    if ({bus_valid3, bus_out3} !== {1'b0, (KEEP ? 32'hCAFEF00D : 32'h0)}) begin
      tests_failed++;
      $display("FAIL b2b_drain: valid=%b out=%h, want 0 %h", bus_valid3, bus_out3, (KEEP ? 32'hCAFEF00D : 32'h0));
    end
  endtask

  task automatic test_conflict();
    out_en3 = (24'd1 << 2) | (24'd1 << 7);
    req3 = 1'b1;
    step();
    out_en3 = 24'd1 << 5;
    tests_run++;
    if ({err3, err_cnt3, ready3, bus_valid3} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL conflict_enter: err=%b cnt=%0d rdy=%b valid=%b, want 1 1 0 0", err3, err_cnt3, ready3, bus_valid3);
    end
    tests_run++;
    if (bus_out3 !== (KEEP ? 32'hCAFEF00D : 32'h0)) begin
      tests_failed++;
      $display("FAIL conflict_bus: out=%h, want %h", bus_out3, (KEEP ? 32'hCAFEF00D : 32'h0));
    end
    step();
    step();
    tests_run++;
    if ({err3, err_cnt3, bus_valid3, sel_idx3} !== {1'b1, 8'd1, 1'b0, 5'd9}) begin
      tests_failed++;
      $display("FAIL conflict_req_ignored: err=%b cnt=%0d valid=%b sel=%0d, want 1 1 0 9", err3, err_cnt3, bus_valid3, sel_idx3);
    end
    err_clr3 = 1'b1;
    step();
    err_clr3 = 1'b0;
    req3 = 1'b0;
    tests_run++;
    if ({err3, err_cnt3, bus_valid3, ready3, sel_idx3} !== {1'b0, 8'd1, 1'b0, 1'b1, 5'd9}) begin
      tests_failed++;
      $display("FAIL conflict_clear: err=%b cnt=%0d valid=%b rdy=%b sel=%0d, want 0 1 0 1 9",
               err3, err_cnt3, bus_valid3, ready3, sel_idx3);
    end
    for (int i = 0; i < 299; i++) begin
      out_en3 = (24'd1 << 2) | (24'd1 << 7);
      req3 = 1'b1;
      step();
      req3 = 1'b0;
      err_clr3 = 1'b1;
      step();
      err_clr3 = 1'b0;
    end
    out_en3 = '0;
    tests_run++;
    if ({err_cnt3, err3} !== {8'd255, 1'b0}) begin
      tests_failed++;
      $display("FAIL conflict_saturate: cnt=%0d err=%b, want 255 0", err_cnt3, err3);
    end
  endtask

  task automatic test_reset_mid_drive();
    out_en3 = 24'd1 << 5;
    req3 = 1'b1;
    step();
    req3 = 1'b0;
    out_en3 = '0;
    tests_run++;
    if ({bus_valid3, bus_out3, sel_idx3} !== {1'b1, 32'h12345678, 5'd5}) begin
      tests_failed++;
      $display("FAIL pre_reset_drive: valid=%b out=%h sel=%0d, want 1 12345678 5", bus_valid3, bus_out3, sel_idx3);
    end
    #2;
    clear_n = 1'b0;
    #1;
    tests_run++;
    if ({bus_valid3, bus_out3, err3, err_cnt3, sel_idx3, ready3} !== {1'b0, 32'h0, 1'b0, 8'd0, 5'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_drive: valid=%b out=%h err=%b cnt=%0d sel=%0d rdy=%b, want 0 0 0 0 0 1",
               bus_valid3, bus_out3, err3, err_cnt3, sel_idx3, ready3);
    end
    step();
    clear_n = 1'b1;
    step();
    tests_run++;
    if ({ready3, bus_valid3} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: rdy=%b valid=%b, want 1 0", ready3, bus_valid3);
    end
  endtask

  task automatic test_zero_keeper();
    src_data[3*DW +: DW] = 32'hA5A5A5A5;
    out_en1 = 24'd1 << 3;
    req1 = 1'b1;
    step();
    out_en1 = '0;
    tests_run++;
    if ({bus_valid1, bus_out1, sel_idx1} !== {1'b1, 32'hA5A5A5A5, 5'd3}) begin
      tests_failed++;
      $display("FAIL zero_pre_drive: valid=%b out=%h sel=%0d, want 1 a5a5a5a5 3", bus_valid1, bus_out1, sel_idx1);
    end
    step();
    req1 = 1'b0;
    tests_run++;
    if ({bus_valid1, sel_idx1, err1, ready1} !== {1'b0, 5'd3, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL zero_noop: valid=%b sel=%0d err=%b rdy=%b, want 0 3 0 1", bus_valid1, sel_idx1, err1, ready1);
    end
    tests_run++;
    if (bus_out1 !== (KEEP ? 32'hA5A5A5A5 : 32'h0)) begin
      tests_failed++;
      $display("FAIL zero_keeper: out=%h, want %h", bus_out1, (KEEP ? 32'hA5A5A5A5 : 32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_conflict();
    test_reset_mid_drive();
    test_zero_keeper();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
